// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ requesters, with an s_tick idle gap after each frame.
// Optional per-frame timeout abort is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DBIT          = 8,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_tick,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DBIT-1:0]         din,
  output logic [NREQ-1:0]              ack,
  output logic [NREQ-1:0]              done,
  output logic                         tx_start,
  output logic [DBIT-1:0]              tx_din,
  input  logic                         tx_done_tick,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      cur_id,
  output logic                         err,
  output logic [1:0]                   state_dbg
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_TICKS);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_TICKS < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_TICKS >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  // Handshake: req is a level held by the requester until its one-clk ack;
  // ack marks the cycle its din slice was latched into tx_din.
  state_t            state, state_n;
  logic [ID_W-1:0]   rr_ptr, rr_n;
  logic [NREQ-1:0]   ack_n, done_n;
  logic [DBIT-1:0]   tx_din_n;
  logic [ID_W-1:0]   cur_id_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              err_n;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_TICKS);
  logic [TO_W-1:0] to_cnt, to_n;
`endif

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    ack_n    = '0;
    done_n   = '0;
    err_n    = 1'b0;
    tx_din_n = tx_din;
    cur_id_n = cur_id;
    gap_n    = gap_cnt;
`ifdef UART_ARB_TIMEOUT_EN
    to_n     = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (grant_found) begin
          tx_din_n        = din[int'(grant_id)*DBIT +: DBIT];
          cur_id_n        = grant_id;
          ack_n[grant_id] = 1'b1;
          state_n         = START;
        end
      end
      START: begin
        rr_n    = ID_W'((int'(cur_id) + 1) % NREQ);
        gap_n   = '0;
`ifdef UART_ARB_TIMEOUT_EN
        to_n    = '0;
`endif
        state_n = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          done_n[cur_id] = 1'b1;
          state_n        = (GAP_TICKS == 0) ? IDLE : GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // A done tick in the timeout cycle takes priority over the abort.
        else if (s_tick) begin
          if (to_cnt + TO_W'(1) == TO_END) begin
            err_n   = 1'b1;
            state_n = (GAP_TICKS == 0) ? IDLE : GAP;
          end else begin
            to_n = to_cnt + TO_W'(1);
          end
        end
`endif
      end
      GAP: begin
        if (s_tick) begin
          if (gap_cnt + GAP_W'(1) == GAP_END) begin
            gap_n   = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap_cnt + GAP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      ack     <= '0;
      done    <= '0;
      tx_din  <= '0;
      cur_id  <= '0;
      gap_cnt <= '0;
      err     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      state   <= state_n;
      rr_ptr  <= rr_n;
      ack     <= ack_n;
      done    <= done_n;
      tx_din  <= tx_din_n;
      cur_id  <= cur_id_n;
      gap_cnt <= gap_n;
`ifdef UART_ARB_TIMEOUT_EN
      err     <= err_n;
      to_cnt  <= to_n;
`else
      err     <= 1'b0;
`endif
    end
  end

`ifndef UART_ARB_TIMEOUT_EN
  logic unused_err_n;
  assign unused_err_n = err_n;
`endif

  assign tx_start  = (state == START);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx stand-in plus a scoreboard of expected ack/byte/done events.
// Build with UART_ARB_TIMEOUT_EN to add the timeout abort scenario.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int GAP  = 16;
  localparam int FRAME_TICKS = 160;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 200;
`else
  localparam int TO = 256;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_tick = 1'b0;
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] din;
  logic [NREQ-1:0]      ack, done;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;
  logic                 busy;
  logic [1:0]           cur_id;
  logic                 err;
  logic [1:0]           state_dbg;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(rst), .s_tick(s_tick), .req(req), .din(din), .ack(ack), .done(done),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick), .busy(busy),
    .cur_id(cur_id), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset / tick
  always #5 clk = ~clk;
  always @(posedge clk) s_tick <= rst ? 1'b0 : ~s_tick;

  // uart_tx stand-in: 10-bit frame, 16 s_ticks per bit
  logic       model_en;
  logic       m_busy;
  int         m_ticks;
  logic [7:0] m_byte;
  logic       tx;
  wire  [9:0] m_frame = {1'b1, m_byte, 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; tx <= 1'b1; tx_done_tick <= 1'b0; m_ticks <= 0; m_byte <= '0;
    end else begin
      tx_done_tick <= 1'b0;
      if (tx_start) begin
        m_busy <= 1'b1; m_byte <= tx_din; m_ticks <= 0; tx <= 1'b0;
      end else if (m_busy && s_tick) begin
        if (m_ticks == FRAME_TICKS - 1) begin
          m_busy <= 1'b0; tx <= 1'b1;
          if (model_en) tx_done_tick <= 1'b1;
        end else begin
          m_ticks <= m_ticks + 1;
          tx <= m_frame[(m_ticks + 1) / 16];
        end
      end
    end
  end

  // scoreboard
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] exp_ack_q[$];
  logic [7:0] exp_byte_q[$];
  logic [1:0] exp_done_q[$];
  int         exp_err_cnt = 0;
  int         gcnt = 0;
  bit         gap_armed = 0;
  int         tcnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(logic [1:0] id, logic [7:0] b, bit with_done);
    exp_ack_q.push_back(id);
    exp_byte_q.push_back(b);
    if (with_done) exp_done_q.push_back(id);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      gap_armed = 0;
    end else begin
      if (ack != '0) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", 32'(ack), 0);
        else check("ack", 32'(ack), 32'(4'b0001 << exp_ack_q.pop_front()));
        check("ack_done_excl", 32'(done), 0);
      end
      if (tx_start) begin
        if (exp_byte_q.size() == 0) check("start_unexpected", 1, 0);
        else check("tx_din_at_start", 32'(tx_din), 32'(exp_byte_q.pop_front()));
        if (gap_armed) check("gap_respected", 32'(gcnt >= GAP), 1);
        gap_armed = 0;
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 0);
        else check("done", 32'(done), 32'(4'b0001 << exp_done_q.pop_front()));
      end
      if (tx_done_tick) check("tx_din_stable", 32'(tx_din), 32'(m_byte));
      if (err) begin
        if (exp_err_cnt == 0) check("err_unexpected", 32'(err), 0);
        else begin
          exp_err_cnt--;
          check("err_tick_count", tcnt, TO);
          check("err_no_done", 32'(done), 0);
        end
      end
      if (done != '0 || err) begin gcnt = 0; gap_armed = 1; end
      if (s_tick) begin gcnt++; tcnt++; end
      if (tx_start) tcnt = 0;
    end
  end

  // driver helpers
  function automatic bit cond(int sel, int id);
    case (sel)
      0: return ack[id];
      1: return !busy;
      3: return done[id];
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(int sel, int id, int budget, string name);
    int n = 0;
    @(negedge clk);
    while (!cond(sel, id) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel, id)) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    #12 rst = 1'b0;
  endtask

  initial begin
    int t, n;
    rst = 1'b1; req = '0; din = '0; model_en = 1'b1;

    // reset values
    #12;
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_din", 32'(tx_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cur_id", 32'(cur_id), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(state_dbg), 0);
    #10 rst = 1'b0;

    // single request, one-clock grant latency, gap length
    @(posedge clk); #1;
    expect_frame(2'd1, 8'hAB, 1);
    din[15:8] = 8'hAB; req = 4'b0010;
    @(posedge clk); @(negedge clk);
    check("ack_latency", 32'(ack), 32'(4'b0010));
    req = '0;
    wait_for(3, 1, 2000, "done1");
    check("busy_at_done", 32'(busy), 1);
    t = 0; n = 0;
    while (busy && n < 200) begin
      if (s_tick) t++;
      @(negedge clk);
      n++;
    end
    check("gap_ticks", t, GAP);
    check("busy_low_after_gap", 32'(busy), 0);

    // round robin from a fresh rr_ptr
    pulse_reset();
    expect_frame(2'd0, 8'h11, 1); expect_frame(2'd1, 8'h22, 1);
    expect_frame(2'd2, 8'h33, 1); expect_frame(2'd3, 8'h44, 1);
    expect_frame(2'd0, 8'h55, 1);
    din = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
    wait_for(0, 0, 2000, "rr_ack0");
    din[7:0] = 8'h55;
    wait_for(0, 1, 2000, "rr_ack1");
    wait_for(0, 2, 2000, "rr_ack2");
    wait_for(0, 3, 2000, "rr_ack3");
    wait_for(0, 0, 2000, "rr_ack0b");
    req = '0;
    wait_for(1, 0, 2000, "rr_idle");

    // sole requester back-to-back, gap enforced between frames
    expect_frame(2'd0, 8'h66, 1); expect_frame(2'd0, 8'h77, 1);
    din[7:0] = 8'h66; req = 4'b0001;
    wait_for(0, 0, 2000, "b2b_ack_a");
    din[7:0] = 8'h77;
    wait_for(0, 0, 2000, "b2b_ack_b");
    req = '0;
    wait_for(1, 0, 2000, "b2b_idle");

    // request dropped before it could be granted
    expect_frame(2'd3, 8'h5A, 1);
    din[31:24] = 8'h5A; req = 4'b1000;
    wait_for(0, 3, 2000, "drop_ack3");
    req = '0;
    repeat (5) @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk); #1 req = '0;
    wait_for(1, 0, 2000, "drop_idle");
    repeat (20) @(negedge clk);
    check("drop_no_grant_busy", 32'(busy), 0);
    check("drop_cur_id", 32'(cur_id), 3);

    // reset during WAIT aborts without done
    expect_frame(2'd1, 8'hC3, 0);
    din[15:8] = 8'hC3; req = 4'b0010;
    wait_for(0, 1, 2000, "rstmid_ack");
    req = '0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmid_tx_start", 32'(tx_start), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_tx", 32'(tx), 1);
    check("rstmid_done", 32'(done), 0);
    #12 rst = 1'b0;
    expect_frame(2'd2, 8'h3C, 1);
    din[23:16] = 8'h3C; req = 4'b0100;
    wait_for(0, 2, 2000, "rstmid_ack2");
    req = '0;
    wait_for(1, 0, 2000, "rstmid_idle");

`ifdef UART_ARB_TIMEOUT_EN
    // no tx_done_tick: abort after TO ticks, then the next request is served
    model_en = 1'b0;
    exp_err_cnt = 1;
    expect_frame(2'd0, 8'h99, 0);
    din[7:0] = 8'h99; req = 4'b0001;
    wait_for(0, 0, 2000, "to_ack0");
    req = '0;
    wait_for(1, 0, 2000, "to_idle");
    check("to_err_seen", exp_err_cnt, 0);
    model_en = 1'b1;
    expect_frame(2'd1, 8'h42, 1);
    din[15:8] = 8'h42; req = 4'b0010;
    wait_for(0, 1, 2000, "to_ack1");
    req = '0;
    wait_for(1, 0, 2000, "to_idle2");
`endif

    repeat (5) @(negedge clk);
    check("exp_ack_q_empty", exp_ack_q.size(), 0);
    check("exp_byte_q_empty", exp_byte_q.size(), 0);
    check("exp_done_q_empty", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
